intersection_scheduler: RTL
===========================

Name: intersection_scheduler

Overview:
- Sequences right-of-way between two approaches, north-south (NS) and east-west (EW), each driving one R/G/Y lamp set.
- Latches vehicle/pass requests from both approaches and holds a green phase between a minimum and a maximum dwell.
- Inserts mandatory yellow and all-red clearance phases at every handover.
- Sits above the per-lamp light drivers and owns all phase timing for the intersection.

Parameters:
GREEN_MIN, 512, minimum green dwell in cycles before a handover may start
GREEN_MAX, 1024, maximum green dwell; handover is forced at this count even with no opposing request
YELLOW_LEN, 256, yellow dwell in cycles
ALLRED_LEN, 64, all-red clearance dwell in cycles
CNT_W, 11, phase counter width; must satisfy 2^CNT_W >= GREEN_MAX

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_ns  input  1  request for NS right-of-way, level or single-cycle pulse
req_ew  input  1  request for EW right-of-way, level or single-cycle pulse
ns_r, ns_y, ns_g  output  1 each  NS lamps, registered
ew_r, ew_y, ew_g  output  1 each  EW lamps, registered
phase  output  3  current state encoding, registered
pend_ns, pend_ew  output  1 each  latched pending-request flags

Behaviour:
- Reset (async on rst_n low, applies in any state):
  - phase=NS_GREEN, cnt=0, pend_ns=pend_ew=0.
  - ns_g=1, ns_r=0, ns_y=0, ew_r=1, ew_g=0, ew_y=0.
- Phase encoding: 0 NS_GREEN, 1 NS_YELLOW, 2 ALLRED_A, 3 EW_GREEN, 4 EW_YELLOW, 5 ALLRED_B, 6 FLASH (optional), 7 unused.
- Any unused encoding returns to NS_GREEN on the next edge.
- Lamp outputs and phase update on the same edge, so a phase of length N shows its lamps for exactly N cycles.
- Lamps per phase:
  - NS_GREEN: ns_g, ew_r.
  - NS_YELLOW: ns_y, ew_r.
  - ALLRED_A and ALLRED_B: ns_r, ew_r.
  - EW_GREEN: ew_g, ns_r.
  - EW_YELLOW: ew_y, ns_r.
  - At most one lamp per approach is ever lit.
- Counter:
  - cnt clears to 0 on every phase entry and increments each cycle.
  - A fixed phase of length L exits when cnt==L-1.
  - cnt saturates and never wraps.
- Request latch:
  - pend_ew sets on req_ew in any phase except EW_GREEN; it clears on the edge entering EW_GREEN. pend_ns is symmetric.
  - A request for the approach currently green is ignored.
  - If a request and entry into its own green occur on the same edge, clear wins.
- Green exit (NS_GREEN; EW_GREEN is symmetric):
  - Let opp = pend_ew | req_ew.
  - Go to NS_YELLOW when cnt>=GREEN_MIN-1 and opp=1, or when cnt==GREEN_MAX-1.
  - Net effect: a request arriving after the minimum has elapsed starts yellow on the next edge.
- Fixed sequence: NS_GREEN -> NS_YELLOW -> ALLRED_A -> EW_GREEN -> EW_YELLOW -> ALLRED_B -> NS_GREEN.
- Mid-sequence events: no request can abort or skip a yellow or all-red phase once it has started.

Optional Feature:
- Macro: INTERSECTION_FLASH_EN.
- Defined:
  - Adds input port flash (1 bit).
  - flash=1 sampled in any phase moves to FLASH on the next edge, clearing pend_ns and pend_ew.
  - In FLASH, ns_y and ew_r toggle together every 64 cycles, starting at 1. All other lamps are 0, and requests are ignored.
  - flash=0 moves to ALLRED_B on the next edge, then to NS_GREEN.
- Undefined: no flash port; encoding 6 is unreachable and treated as unused.

Test Plan:
1. Reset released at cycle 0, no requests -> ns_g=1 for cycles 0-1023, ns_y 1024-1279, all-red 1280-1343, ew_g from 1344.
2. req_ew pulse at cycle 10 -> pend_ew=1 from 11; ns_g through 511, ns_y 512-767, all-red 768-831, ew_g at 832 with pend_ew=0.
3. req_ew pulse at cycle 700 -> ns_y from cycle 701; pulse at 1023 gives the same timing as the forced exit.
4. req_ns pulse during NS_GREEN is ignored (pend_ns stays 0); req_ns during NS_YELLOW sets pend_ns -> EW_GREEN lasts exactly 512 cycles.
5. rst_n low for 3 cycles mid EW_GREEN with pend_ns=1 -> outputs reach NS_GREEN values immediately with pend flags 0; normal timing restarts at cnt=0.
6. (INTERSECTION_FLASH_EN) flash=1 during EW_YELLOW -> phase=6, ns_y/ew_r toggle every 64 cycles; flash=0 -> 64 cycles all-red, then ns_g.

Source files
------------

// File: rtl/intersection_scheduler.sv
// -----------------------------------------------------------------------------
// intersection_scheduler
//
// Controls right-of-way between the north-south (NS) and east-west (EW)
// approaches. It latches requests from both approaches and holds each green
// phase between GREEN_MIN and GREEN_MAX cycles. Every handover passes through
// a yellow phase and then an all-red clearance phase.
//
// Optional feature: defining INTERSECTION_FLASH_EN adds the `flash` input and
// the FLASH phase (encoding 6). In FLASH, the NS yellow and EW red lamps blink
// together with a 64-cycle half period.
//
// Ports:
//   clk               system clock, rising edge
//   rst_n             asynchronous active-low reset
//   req_ns, req_ew    right-of-way requests (level or single-cycle pulse)
//   flash             (INTERSECTION_FLASH_EN only) flashing-mode request
//   ns_r/ns_y/ns_g    NS lamps, registered
//   ew_r/ew_y/ew_g    EW lamps, registered
//   phase             current phase encoding, registered
//                     0 NS_GREEN, 1 NS_YELLOW, 2 ALLRED_A, 3 EW_GREEN,
//                     4 EW_YELLOW, 5 ALLRED_B, 6 FLASH, 7 unused
//   pend_ns, pend_ew  latched pending-request flags
// -----------------------------------------------------------------------------
module intersection_scheduler #(
  parameter int GREEN_MIN  = 512,
  parameter int GREEN_MAX  = 1024,
  parameter int YELLOW_LEN = 256,
  parameter int ALLRED_LEN = 64,
  parameter int CNT_W      = 11
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req_ns,
  input  logic       req_ew,
`ifdef INTERSECTION_FLASH_EN
  input  logic       flash,
`endif
  output logic       ns_r,
  output logic       ns_y,
  output logic       ns_g,
  output logic       ew_r,
  output logic       ew_y,
  output logic       ew_g,
  output logic [2:0] phase,
  output logic       pend_ns,
  output logic       pend_ew
);

  typedef enum logic [2:0] {
    NS_GREEN  = 3'd0,
    NS_YELLOW = 3'd1,
    ALLRED_A  = 3'd2,
    EW_GREEN  = 3'd3,
    EW_YELLOW = 3'd4,
    ALLRED_B  = 3'd5,
    FLASH     = 3'd6,
    UNUSED    = 3'd7
  } phase_t;

  localparam logic [CNT_W-1:0] G_MIN_M1  = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] G_MAX_M1  = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_M1    = CNT_W'(YELLOW_LEN - 1);
  localparam logic [CNT_W-1:0] RED_M1    = CNT_W'(ALLRED_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  // The phase counter holds at its maximum value. It never wraps, so a stuck
  // phase cannot appear to restart its dwell time.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  phase_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             pend_ns_nxt, pend_ew_nxt;
  logic [5:0]       lamps, lamps_nxt;   // {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g}
  logic             entering;
  logic             req_ok;

`ifdef INTERSECTION_FLASH_EN
  logic [5:0] flash_tmr, flash_tmr_nxt;
  logic       flash_lamp, flash_lamp_nxt;
`endif

  // ---- stage: next-state / next-output decode ----
  always_comb begin
    state_nxt = state;
    case (state)
      NS_GREEN:
        if ((cnt >= G_MIN_M1 && (pend_ew || req_ew)) || cnt == G_MAX_M1)
          state_nxt = NS_YELLOW;
      NS_YELLOW: if (cnt == YEL_M1) state_nxt = ALLRED_A;
      ALLRED_A:  if (cnt == RED_M1) state_nxt = EW_GREEN;
      EW_GREEN:
        if ((cnt >= G_MIN_M1 && (pend_ns || req_ns)) || cnt == G_MAX_M1)
          state_nxt = EW_YELLOW;
      EW_YELLOW: if (cnt == YEL_M1) state_nxt = ALLRED_B;
      ALLRED_B:  if (cnt == RED_M1) state_nxt = NS_GREEN;
`ifdef INTERSECTION_FLASH_EN
      FLASH:     if (!flash) state_nxt = ALLRED_B;
`endif
      default:   state_nxt = NS_GREEN;
    endcase
`ifdef INTERSECTION_FLASH_EN
    // Flash overrides every phase, including yellow and all-red.
    if (flash) state_nxt = FLASH;
`endif
  end

  always_comb begin
    entering = (state_nxt != state);
    cnt_nxt  = entering ? '0 : sat_inc(cnt);

`ifdef INTERSECTION_FLASH_EN
    req_ok = (state != FLASH);
`else
    req_ok = 1'b1;
`endif

    // Entry into an approach's own green clears its request. The clear is
    // applied after the set, so it wins when both occur on the same edge.
    pend_ns_nxt = pend_ns;
    pend_ew_nxt = pend_ew;
    if (req_ok && req_ns && state != NS_GREEN) pend_ns_nxt = 1'b1;
    if (req_ok && req_ew && state != EW_GREEN) pend_ew_nxt = 1'b1;
    if (entering && state_nxt == NS_GREEN) pend_ns_nxt = 1'b0;
    if (entering && state_nxt == EW_GREEN) pend_ew_nxt = 1'b0;

`ifdef INTERSECTION_FLASH_EN
    flash_tmr_nxt  = flash_tmr;
    flash_lamp_nxt = flash_lamp;
    if (state_nxt == FLASH) begin
      pend_ns_nxt = 1'b0;
      pend_ew_nxt = 1'b0;
      if (entering) begin
        flash_tmr_nxt  = '0;
        flash_lamp_nxt = 1'b1;
      end else begin
        flash_tmr_nxt = flash_tmr + 6'd1;
        if (flash_tmr == 6'd63) flash_lamp_nxt = ~flash_lamp;
      end
    end
`endif

    // The lamps are decoded from the next phase. They are then registered on
    // the same edge as the phase, so each lamp stays lit for the full phase.
    lamps_nxt = 6'b000_000;
    case (state_nxt)
      NS_GREEN:  lamps_nxt = 6'b001_100;
      NS_YELLOW: lamps_nxt = 6'b010_100;
      ALLRED_A:  lamps_nxt = 6'b100_100;
      EW_GREEN:  lamps_nxt = 6'b100_001;
      EW_YELLOW: lamps_nxt = 6'b100_010;
      ALLRED_B:  lamps_nxt = 6'b100_100;
`ifdef INTERSECTION_FLASH_EN
      FLASH:     lamps_nxt = {1'b0, flash_lamp_nxt, 1'b0, flash_lamp_nxt, 2'b00};
`endif
      default:   lamps_nxt = 6'b100_100;
    endcase
  end

  // ---- stage: registered state and outputs ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= NS_GREEN;
      cnt     <= '0;
      pend_ns <= 1'b0;
      pend_ew <= 1'b0;
      lamps   <= 6'b001_100;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pend_ns <= pend_ns_nxt;
      pend_ew <= pend_ew_nxt;
      lamps   <= lamps_nxt;
    end
  end

`ifdef INTERSECTION_FLASH_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flash_tmr  <= '0;
      flash_lamp <= 1'b0;
    end else begin
      flash_tmr  <= flash_tmr_nxt;
      flash_lamp <= flash_lamp_nxt;
    end
  end
`endif

  assign {ns_r, ns_y, ns_g, ew_r, ew_y, ew_g} = lamps;
  assign phase = state;

endmodule
